// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes big-endian 32-bit
// words into instruction memory, then releases the processor from reset.
module imem_loader #(
  parameter int MAX_WORDS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_BYTES,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  // Common width for comparing the word index against the 8-bit length byte.
  localparam int         CMP_W = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

  state_t            state;
  state_t            state_next;
  logic [7:0]        n_words;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [23:0]       word_buf;

  logic xfer;
  logic len_ok;
  logic last_word;

  assign xfer      = byte_valid && byte_ready;
  assign len_ok    = (byte_data != 8'd0) && (byte_data <= MAX_N);
  assign last_word = (CMP_W'(word_idx) == (CMP_W'(n_words) - CMP_W'(1)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: default assignment first so no path through the case leaves
  // state_next unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_LEN;
      S_LEN:   if (xfer) state_next = len_ok ? S_BYTES : S_ERR;
      S_BYTES: if (xfer && (byte_cnt == 2'd3)) state_next = S_WRITE;
      S_WRITE: state_next = last_word ? S_DONE : S_BYTES;
      S_DONE:  if (start) state_next = S_LEN;
      S_ERR:   if (start) state_next = S_LEN;
      default: state_next = S_IDLE;
    endcase
    // Abort wins over start and over any byte offered in the same cycle.
    if (abort) state_next = S_IDLE;
  end

  always_comb begin
    byte_ready = ((state == S_LEN) || (state == S_BYTES)) && !abort;
    wr_en      = (state == S_WRITE) && !abort;
    cpu_reset  = (state != S_DONE);
    done       = (state == S_DONE);
    error      = (state == S_ERR);
  end

  // Datapath: length, counters, partial word and the held write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_words  <= 8'd0;
      byte_cnt <= 2'd0;
      word_idx <= '0;
      word_buf <= 24'd0;
      wr_addr  <= '0;
      wr_data  <= 32'd0;
    end else if (abort) begin
      byte_cnt <= 2'd0;
      word_idx <= '0;
    end else begin
      unique case (state)
        S_LEN: begin
          if (xfer) begin
            n_words  <= byte_data;
            byte_cnt <= 2'd0;
            word_idx <= '0;
          end
        end
        S_BYTES: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            unique case (byte_cnt)
              2'd0: word_buf[23:16] <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[7:0]   <= byte_data;
              default: begin
                // Present the complete word on the write port for the WRITE cycle.
                wr_data <= {word_buf, byte_data};
                wr_addr <= word_idx;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (!last_word) word_idx <= word_idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  a_write_in_range : assert property (@(posedge clk) disable iff (reset)
    wr_en |-> (CMP_W'(wr_addr) < CMP_W'(n_words)));

  a_no_ready_in_write : assert property (@(posedge clk) disable iff (reset)
    wr_en |-> !byte_ready);

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a driver streams length-prefixed images while a
// monitor pops expected writes from a scoreboard built from the image contents.
module tb_imem_loader;

  localparam int MAX_WORDS = 16;
  localparam int ADDR_W    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_loader #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  wr_cycles[$];
  wr_t mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (wr_en) begin
      check("byte_ready_in_write", byte_ready, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", wr_addr, wr_data);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", wr_addr, mon_e.addr);
        check("wr_data", wr_data, mon_e.data);
      end
      wr_cycles.push_back(cyc);
    end
  end

  function automatic int gap_of(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic pulse_start(output int c0);
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    logic rdy;
    bit   got;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    if (noise) start = 1'($urandom_range(0, 1));
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk); #1;
      if (rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("byte_handshake_timeout");
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic wait_end(input int c0, output int lat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done || error) begin
        seen = 1'b1;
        break;
      end
    end
    lat = cyc - c0;
    if (!seen) fail_now("done_or_error_timeout");
  endtask

  // pat: 0 random words, 1 alternating 0x00000000/0xFFFFFFFF, 2 and 3 fixed words.
  task automatic load(input int n, input int gap_mode, input int pat, input bit noise);
    int          c0;
    int          lat;
    logic [31:0] w;
    pulse_start(c0);
    send_byte(8'(n), gap_of(gap_mode), 1'b0);
    if (n == 0 || n > MAX_WORDS) begin
      wait_end(c0, lat);
      check("err_error", error, 1);
      check("err_done", done, 0);
      check("err_cpu_reset", cpu_reset, 1);
      return;
    end
    wr_cycles.delete();
    for (int i = 0; i < n; i++) begin
      case (pat)
        0:       w = $urandom;
        1:       w = (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
        2:       w = 32'h2001_0005;
        default: w = 32'hA1B2_C3D4;
      endcase
      sb.push_back('{i, w});
      for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8], gap_of(gap_mode), noise);
    end
    wait_end(c0, lat);
    check("load_done", done, 1);
    check("load_cpu_reset", cpu_reset, 0);
    check("load_error", error, 0);
    check("pending_writes", sb.size(), 0);
    check("write_count", wr_cycles.size(), n);
    check("held_wr_addr", wr_addr, n - 1);
    check("held_wr_data", wr_data, w);
    if (gap_mode == 0) begin
      check("done_latency", lat, 2 + 5 * n);
      for (int i = 1; i < wr_cycles.size(); i++)
        check("write_spacing", wr_cycles[i] - wr_cycles[i-1], 5);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          c0;
    logic [31:0] w0;
    logic [31:0] w1;

    reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    idle(1);

    // Single word, continuous stream, plus a three-word image.
    load(1, 0, 2, 1'b0);
    load(3, 0, 0, 1'b0);

    // Illegal lengths, then a good load straight out of the error state.
    load(0, 0, 0, 1'b0);
    load(17, 0, 0, 1'b0);
    load(255, 0, 0, 1'b0);
    load(1, 0, 0, 1'b0);

    // Largest image, and byte_valid toggling every other cycle.
    load(MAX_WORDS, 0, 0, 1'b0);
    load(2, 1, 1, 1'b0);

    // Abort during byte 2 of word 1.
    pulse_start(c0);
    send_byte(8'd4, 0, 1'b0);
    w0 = $urandom;
    w1 = $urandom;
    sb.push_back('{0, w0});
    for (int j = 0; j < 4; j++) send_byte(w0[31-8*j -: 8], 0, 1'b0);
    send_byte(w1[31:24], 0, 1'b0);
    send_byte(w1[23:16], 0, 1'b0);
    byte_valid = 1'b1; byte_data = w1[15:8]; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    check("abort_byte_ready", byte_ready, 0);
    check("abort_cpu_reset", cpu_reset, 1);
    check("abort_done", done, 0);
    idle(10);
    check("abort_pending", sb.size(), 0);

    // Start, byte and abort together in IDLE, then in LEN.
    start = 1'b1; abort = 1'b1; byte_valid = 1'b1; byte_data = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    check("abort_start_idle", byte_ready, 0);
    pulse_start(c0);
    start = 1'b1; abort = 1'b1; byte_valid = 1'b1; byte_data = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    check("abort_in_len", byte_ready, 0);
    idle(8);

    // Abort together with start while DONE.
    load(1, 0, 0, 1'b0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_done_cpu_reset", cpu_reset, 1);
    check("abort_done_done", done, 0);
    check("abort_done_ready", byte_ready, 0);

    // Reset mid-word beats start and abort; reload lands byte 0 in [31:24].
    pulse_start(c0);
    send_byte(8'd2, 0, 1'b0);
    send_byte(8'h5A, 0, 1'b0);
    send_byte(8'h6B, 0, 1'b0);
    reset = 1'b1; start = 1'b1; abort = 1'b1; byte_valid = 1'b1; byte_data = 8'hEE;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_byte_ready", byte_ready, 0);
    check("midrst_cpu_reset", cpu_reset, 1);
    idle(6);
    load(1, 0, 3, 1'b0);

    // Randomised images with random gaps and start noise mid-load.
    for (int k = 0; k < 5; k++) load(int'($urandom_range(1, MAX_WORDS)), 2, 0, 1'b1);

    idle(5);
    check("final_pending", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
